// File: rtl/vga_framebuffer_if.sv
// Bus-side and timing-side signals of the indexed-colour framebuffer.
// The master drives commands and read coordinates; the slave is the framebuffer itself.
interface vga_framebuffer_if;
    logic [10:0] x;
    logic [9:0]  y;
    logic [31:0] bus_wdata;
    logic        vga_we;
    logic        frame_trig;
    logic [11:0] colour_out;
    logic        busy;
    logic        cmd_drop;

    modport master (
        output x, y, bus_wdata, vga_we, frame_trig,
        input  colour_out, busy, cmd_drop
    );

    modport slave (
        input  x, y, bus_wdata, vga_we, frame_trig,
        output colour_out, busy, cmd_drop
    );
endinterface

// File: rtl/vga_framebuffer.sv
// Indexed-colour framebuffer with a writable RGB444 palette, a hardware fill engine
// (immediate or frame-synchronous) and a one-cycle-latency read port for VGA scan-out.
module vga_framebuffer #(
    parameter int DISPLAY_WIDTH  = 800,
    parameter int DISPLAY_HEIGHT = 600,
    parameter int BPP            = 2
) (
    input  logic              clk,
    input  logic              rst,
    vga_framebuffer_if.slave  fb
);

    localparam int DEPTH  = DISPLAY_WIDTH * DISPLAY_HEIGHT;
    localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int PAL_N  = 1 << BPP;

    localparam logic [10:0]       W_LIM     = 11'(DISPLAY_WIDTH);
    localparam logic [10:0]       H_LIM     = 11'(DISPLAY_HEIGHT);
    localparam logic [20:0]       W_MUL     = 21'(DISPLAY_WIDTH);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    localparam logic [1:0] OP_PIX  = 2'b00;
    localparam logic [1:0] OP_PAL  = 2'b01;
    localparam logic [1:0] OP_FILL = 2'b10;
    localparam logic [1:0] OP_SYNC = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARMED = 2'd1,
        S_FILL  = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [BPP-1:0]    mem [DEPTH];
    logic [11:0]       pal [PAL_N];

    logic [BPP-1:0]    fill_idx;
    logic [ADDR_W-1:0] fill_addr;

    // ---- stage p0: command decode and read address ----
    logic [1:0]        cmd_op;
    logic [BPP-1:0]    cmd_idx;
    logic [9:0]        cmd_x;
    logic [9:0]        cmd_y;
    logic              cmd_vld_p0;
    logic              cmd_in_range;
    logic [20:0]       cmd_lin;

    logic [20:0]       rd_lin;
    logic              rd_oor_p0;
    logic [ADDR_W-1:0] rd_addr_p0;

    assign cmd_op       = fb.bus_wdata[31:30];
    assign cmd_idx      = fb.bus_wdata[20 +: BPP];
    assign cmd_x        = fb.bus_wdata[9:0];
    assign cmd_y        = fb.bus_wdata[19:10];
    // A strobe coinciding with reset is discarded silently.
    assign cmd_vld_p0   = fb.vga_we && !rst;
    assign cmd_in_range = ({1'b0, cmd_x} < W_LIM) && ({1'b0, cmd_y} < H_LIM);
    assign cmd_lin      = 21'(cmd_y) * W_MUL + 21'(cmd_x);

    assign rd_lin     = 21'(fb.y) * W_MUL + 21'(fb.x);
    assign rd_oor_p0  = (fb.x >= W_LIM) || ({1'b0, fb.y} >= H_LIM);
    assign rd_addr_p0 = rd_oor_p0 ? '0 : rd_lin[ADDR_W-1:0];

    logic unused_bits;
    assign unused_bits = ^{fb.bus_wdata[29:20+BPP], cmd_lin[20:ADDR_W], rd_lin[20:ADDR_W]};

    // Write-port and control outputs of the fill FSM.
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [BPP-1:0]    mem_data;
    logic              pal_we;
    logic              drop_nxt;
    logic              fill_load;
    logic              fill_go;

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (cmd_vld_p0 && cmd_op == OP_FILL)      state_nxt = S_FILL;
                else if (cmd_vld_p0 && cmd_op == OP_SYNC) state_nxt = S_ARMED;
            end
            S_ARMED: if (fb.frame_trig)             state_nxt = S_FILL;
            S_FILL:  if (fill_addr == LAST_ADDR)    state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_data  = '0;
        pal_we    = cmd_vld_p0 && (cmd_op == OP_PAL);
        drop_nxt  = 1'b0;
        fill_load = 1'b0;
        fill_go   = 1'b0;
        case (state)
            S_IDLE: begin
                if (cmd_vld_p0) begin
                    case (cmd_op)
                        OP_PIX: begin
                            if (cmd_in_range) begin
                                mem_we   = 1'b1;
                                mem_addr = cmd_lin[ADDR_W-1:0];
                                mem_data = cmd_idx;
                            end else begin
                                drop_nxt = 1'b1;
                            end
                        end
                        OP_FILL: begin
                            fill_load = 1'b1;
                            fill_go   = 1'b1;
                        end
                        OP_SYNC: fill_load = 1'b1;
                        default: ;
                    endcase
                end
            end
            S_ARMED: begin
                drop_nxt = cmd_vld_p0 && (cmd_op != OP_PAL);
                fill_go  = fb.frame_trig && !rst;
            end
            S_FILL: begin
                drop_nxt = cmd_vld_p0 && (cmd_op != OP_PAL);
                // Reset cuts the fill off before this edge's write lands.
                mem_we   = !rst;
                mem_addr = fill_addr;
                mem_data = fill_idx;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (fill_load) fill_idx <= cmd_idx;
        if (fill_go)                fill_addr <= '0;
        else if (state == S_FILL)   fill_addr <= fill_addr + ADDR_W'(1);
    end

    always_ff @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < PAL_N; i++) pal[i] <= {3{4'(i)}};
        end else if (pal_we) begin
            pal[cmd_idx] <= fb.bus_wdata[11:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) fb.cmd_drop <= 1'b0;
        else     fb.cmd_drop <= drop_nxt;
    end

    // ---- stage p1: registered index and out-of-range flag ----
    logic [BPP-1:0] idx_p1;
    logic           oor_p1;

    always_ff @(posedge clk) begin
        if (rst) begin
            idx_p1 <= '0;
            oor_p1 <= 1'b1;
        end else begin
            idx_p1 <= mem[rd_addr_p0];
            oor_p1 <= rd_oor_p0;
        end
    end

    // Palette lookup stays combinational so palette writes show up on the very next cycle.
    assign fb.colour_out = oor_p1 ? 12'h000 : pal[idx_p1];
    assign fb.busy       = (state != S_IDLE);

endmodule
